mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the pipelined core's instruction-fetch requester and its load/store requester.
- Serialises accesses through a registered request/grant/response FSM with one outstanding transaction.
- Returns per-requester read data with one-cycle valid pulses; the pipeline uses these to stall fetch and memory stages.
- Sits between the core (PC/instr fetch side, ALUResult/WriteData/MemWriteSelect data side) and the shared memory.

Parameters:
- XLEN, 32, address/data width.
- STARVE_LIMIT, 4, max consecutive data grants while fetch waits (used only with the optional feature).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- i_req  input  1  fetch request; held with i_addr stable until i_valid
- i_addr  input  XLEN  fetch address
- i_rdata  output  XLEN  fetched instruction
- i_valid  output  1  one-cycle pulse, i_rdata valid
- d_req  input  1  data request; held with d_* stable until d_valid
- d_we  input  1  1 = store
- d_wstrb  input  4  byte enables for stores
- d_addr  input  XLEN  data address
- d_wdata  input  XLEN  store data
- d_rdata  output  XLEN  load data
- d_valid  output  1  one-cycle pulse, load done or store acknowledged
- mem_req  output  1  memory request, held until mem_gnt
- mem_we  output  1  write enable
- mem_wstrb  output  4  byte enables; 4'b0000 on reads
- mem_addr  output  XLEN  address
- mem_wdata  output  XLEN  write data
- mem_gnt  input  1  memory accepted the request this cycle
- mem_rvalid  input  1  response or write acknowledge
- mem_rdata  input  XLEN  read data
- owner  output  1  0 = fetch owns the port, 1 = data owns it; valid when busy
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, low): FSM to IDLE; all outputs 0 (mem_*, i_/d_rdata, i_/d_valid, owner, busy); starvation counter cleared.
- Reset mid-transaction abandons it. No valid pulse is issued, and any later mem_rvalid is ignored until a new request reaches RESP.

FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - If d_req, grant data (owner = 1); otherwise if i_req, grant fetch (owner = 0).
  - On grant, register mem_addr/mem_we/mem_wstrb/mem_wdata from the chosen requester and go to REQ.
  - Fetches drive mem_we = 0 and mem_wstrb = 0. Data reads (d_we = 0) force mem_wstrb = 0.
- REQ:
  - mem_req = 1; mem_* held constant.
  - On mem_gnt, deassert mem_req next cycle and go to RESP. Otherwise stay, with no limit.
- RESP:
  - Wait for mem_rvalid, any number of cycles; mem_rvalid in IDLE/REQ/DONE is ignored.
  - On mem_rvalid, capture mem_rdata into the owner's rdata register (stores capture nothing) and go to DONE.
- DONE:
  - Owner's valid = 1 for exactly this cycle, then IDLE.
  - The requester samples valid here and must drop or change its request before the next IDLE evaluation, which occurs the cycle after DONE.
- Latency with immediate gnt and rvalid: request seen in IDLE at cycle 0 → mem_req at cycle 1 → RESP at cycle 2 (rvalid) → valid pulse at cycle 3. This gives 4 cycles per access minimum, and back-to-back accesses start every 4 cycles.
- Simultaneous i_req and d_req: data wins (it belongs to an older instruction). Fetch is served on the next IDLE if still requested.
- Rdata registers hold their last value until overwritten; i_valid and d_valid are never high together.
- A requester dropping its req while it is owner is a protocol violation. The arbiter still completes the transaction.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined: a counter tracks consecutive data grants made while i_req was high. When it reaches STARVE_LIMIT, the next IDLE arbitration with both requests pending grants fetch. The counter clears on any fetch grant and on any data grant with i_req low. The counter saturates at STARVE_LIMIT.
- Undefined: strict data priority, and no counter is implemented.

Test Plan:
- Fetch only: i_req = 1, i_addr = 0x0000_0040, mem_gnt immediate, mem_rdata = 0x0051_0093 one cycle later → mem_req high exactly 1 cycle with mem_we = 0, mem_wstrb = 0; i_rdata = 0x0051_0093, i_valid pulses 1 cycle at cycle 3.
- Store: d_req = 1, d_we = 1, d_wstrb = 4'b0011, d_addr = 0x100, d_wdata = 0xDEAD_BEEF → mem_we = 1, mem_wstrb = 4'b0011, mem_wdata = 0xDEAD_BEEF; d_valid pulses after mem_rvalid; d_rdata unchanged.
- Contention: i_req and d_req (load from 0x200) both high at cycle 0 → data served first (owner = 1), then fetch issued in the IDLE following DONE; exactly one i_valid and one d_valid.
- Slow memory: mem_gnt withheld 3 cycles, mem_rvalid 5 cycles after gnt → mem_req held 4 cycles with stable mem_addr; valid pulse 1 cycle after rvalid; busy high throughout.
- Starvation guard (macro defined, STARVE_LIMIT = 4): d_req and i_req held continuously → after 4 data grants, the 5th grant goes to fetch. With the macro undefined, fetch never wins.
- Reset mid-RESP: assert reset low while in RESP, then release and pulse mem_rvalid → all outputs 0 immediately on reset; no i_valid or d_valid; FSM in IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and load/store, one transaction at a time.
// Optional fetch anti-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_valid,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [3:0]      d_wstrb,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_valid,
  output logic            mem_req,
  output logic            mem_we,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            owner,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} stateT;

  stateT           stateReg, stateNext;
  logic            ownerReg, ownerNext;
  logic            memWeReg, memWeNext;
  logic [3:0]      memWstrbReg, memWstrbNext;
  logic [XLEN-1:0] memAddrReg, memAddrNext;
  logic [XLEN-1:0] memWdataReg, memWdataNext;
  logic [XLEN-1:0] iRdataReg, iRdataNext;
  logic [XLEN-1:0] dRdataReg, dRdataNext;
  logic            fetchTurn;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CntW = $clog2(STARVE_LIMIT + 1);
  logic [CntW-1:0] starveCntReg, starveCntNext;

  // Once fetch has watched STARVE_LIMIT data grants go by, it wins the next tie.
  assign fetchTurn = (starveCntReg == CntW'(STARVE_LIMIT));
`else
  assign fetchTurn = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg    <= IDLE;
      ownerReg    <= 1'b0;
      memWeReg    <= 1'b0;
      memWstrbReg <= 4'b0000;
      memAddrReg  <= '0;
      memWdataReg <= '0;
      iRdataReg   <= '0;
      dRdataReg   <= '0;
`ifdef ARB_STARVE_GUARD_EN
      starveCntReg <= '0;
`endif
    end else begin
      stateReg    <= stateNext;
      ownerReg    <= ownerNext;
      memWeReg    <= memWeNext;
      memWstrbReg <= memWstrbNext;
      memAddrReg  <= memAddrNext;
      memWdataReg <= memWdataNext;
      iRdataReg   <= iRdataNext;
      dRdataReg   <= dRdataNext;
`ifdef ARB_STARVE_GUARD_EN
      starveCntReg <= starveCntNext;
`endif
    end
  end

  always_comb begin
    stateNext    = stateReg;
    ownerNext    = ownerReg;
    memWeNext    = memWeReg;
    memWstrbNext = memWstrbReg;
    memAddrNext  = memAddrReg;
    memWdataNext = memWdataReg;
    iRdataNext   = iRdataReg;
    dRdataNext   = dRdataReg;
`ifdef ARB_STARVE_GUARD_EN
    starveCntNext = starveCntReg;
`endif
    case (stateReg)
      IDLE: begin
        // Data normally wins a tie: it belongs to an older instruction.
        if (d_req && !(i_req && fetchTurn)) begin
          ownerNext    = 1'b1;
          memWeNext    = d_we;
          memWstrbNext = d_we ? d_wstrb : 4'b0000;
          memAddrNext  = d_addr;
          memWdataNext = d_wdata;
          stateNext    = REQ;
`ifdef ARB_STARVE_GUARD_EN
          if (!i_req)
            starveCntNext = '0;
          else if (starveCntReg != CntW'(STARVE_LIMIT))
            starveCntNext = starveCntReg + CntW'(1);
`endif
        end else if (i_req) begin
          ownerNext    = 1'b0;
          memWeNext    = 1'b0;
          memWstrbNext = 4'b0000;
          memAddrNext  = i_addr;
          memWdataNext = '0;
          stateNext    = REQ;
`ifdef ARB_STARVE_GUARD_EN
          starveCntNext = '0;
`endif
        end
      end
      REQ: begin
        if (mem_gnt)
          stateNext = RESP;
      end
      RESP: begin
        if (mem_rvalid) begin
          stateNext = DONE;
          if (!ownerReg)
            iRdataNext = mem_rdata;
          else if (!memWeReg)
            dRdataNext = mem_rdata;
        end
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign mem_req   = (stateReg == REQ);
  assign mem_we    = memWeReg;
  assign mem_wstrb = memWstrbReg;
  assign mem_addr  = memAddrReg;
  assign mem_wdata = memWdataReg;
  assign i_rdata   = iRdataReg;
  assign d_rdata   = dRdataReg;
  assign i_valid   = (stateReg == DONE) && !ownerReg;
  assign d_valid   = (stateReg == DONE) && ownerReg;
  assign owner     = ownerReg;
  assign busy      = (stateReg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a delay-configurable memory responder plus per-scenario tasks.
// Starvation expectations follow ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        i_valid, d_valid, mem_req, mem_we, mem_gnt, mem_rvalid, owner, busy;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] iExp[$], dExp[$], obsI[$], obsD[$];
  logic        ownerLog[$], grantWe[$];
  logic [3:0]  grantStrb[$];
  logic [31:0] grantAddr[$], grantWdata[$];
  int          reqStartLog[$];
  int          reqCycles, firstValidCycle, gntDelay, rvDelay;
  bit          timedOut, addrStable, busyAll, bothValid, autoMem;

  mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory responder: grant after gntDelay request cycles, respond rvDelay cycles after the grant cycle.
  initial begin
    logic [31:0] a, wd, old;
    logic        w;
    logic [3:0]  s;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (autoMem && mem_req) begin
        for (int k = 0; k < gntDelay; k++) @(negedge clk);
        mem_gnt = 1'b1;
        a = mem_addr; w = mem_we; s = mem_wstrb; wd = mem_wdata;
        @(negedge clk);
        mem_gnt = 1'b0;
        for (int k = 0; k < rvDelay; k++) @(negedge clk);
        if (w) begin
          old = mem.exists(a) ? mem[a] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (s[b]) old[b*8 +: 8] = wd[b*8 +: 8];
          mem[a] = old;
        end else begin
          mem_rdata = mem.exists(a) ? mem[a] : 32'hBAD0_BAD0;
        end
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Steps negedges until wantValids valid pulses, logging grants and pushing observed rdata.
  task automatic runCycles(input int budget, input int wantValids, input bit dropOnValid);
    int seen = 0;
    bit prevReq = 1'b0;
    logic [31:0] addr0 = '0;
    timedOut = 0; reqCycles = 0; addrStable = 1; busyAll = 1; bothValid = 0; firstValidCycle = -1;
    ownerLog.delete(); grantWe.delete(); grantStrb.delete(); grantAddr.delete();
    grantWdata.delete(); reqStartLog.delete(); obsI.delete(); obsD.delete();
    for (int c = 1; c <= budget && seen < wantValids; c++) begin
      @(negedge clk);
      if (seen == 0 && !busy) busyAll = 0;
      if (mem_req) begin
        reqCycles++;
        if (!prevReq) begin
          addr0 = mem_addr;
          ownerLog.push_back(owner); grantWe.push_back(mem_we); grantStrb.push_back(mem_wstrb);
          grantAddr.push_back(mem_addr); grantWdata.push_back(mem_wdata); reqStartLog.push_back(c);
        end else if (mem_addr !== addr0) addrStable = 0;
      end
      prevReq = mem_req;
      if (i_valid && d_valid) bothValid = 1;
      if (i_valid) begin
        obsI.push_back(i_rdata); seen++;
        if (firstValidCycle < 0) firstValidCycle = c;
        if (dropOnValid) i_req = 1'b0;
      end
      if (d_valid) begin
        obsD.push_back(d_rdata); seen++;
        if (firstValidCycle < 0) firstValidCycle = c;
        if (dropOnValid) d_req = 1'b0;
      end
    end
    timedOut = (seen < wantValids);
    // Pad logs with unknowns so a missing grant shows up as a failed comparison.
    while (ownerLog.size() < 8) begin
      ownerLog.push_back(1'bx); grantWe.push_back(1'bx); grantStrb.push_back(4'bx);
      grantAddr.push_back(32'bx); grantWdata.push_back(32'bx); reqStartLog.push_back(-1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; autoMem = 0; gntDelay = 0; rvDelay = 0;
    i_req = 0; d_req = 0; d_we = 0; d_wstrb = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, i_rdata, d_rdata, i_valid, d_valid, owner, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b mem_req=%b owner=%b i_rdata=%h want all zero", busy, mem_req, owner, i_rdata);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    logic [31:0] want, got;
    mem[32'h40] = 32'h0051_0093; autoMem = 1; gntDelay = 0; rvDelay = 0;
    want = 32'h0051_0093; iExp.push_back(want);
    i_addr = 32'h40; i_req = 1'b1;
    runCycles(20, 1, 1);
    checks++; if (timedOut) begin failures++; $display("FAIL fetch_done got=timeout want=i_valid"); end
    checks++; if (reqCycles !== 1) begin failures++; $display("FAIL fetch_req_cycles got=%0d want=1", reqCycles); end
    checks++; if ({grantWe[0], grantStrb[0]} !== 5'b0) begin failures++; $display("FAIL fetch_we_strb got=%b/%b want=0/0000", grantWe[0], grantStrb[0]); end
    checks++; if (grantAddr[0] !== 32'h40) begin failures++; $display("FAIL fetch_addr got=%h want=00000040", grantAddr[0]); end
    checks++; if (firstValidCycle !== 3) begin failures++; $display("FAIL fetch_latency got=%0d want=3", firstValidCycle); end
    want = iExp.pop_front();
    checks++;
    if (obsI.size() != 1) begin failures++; $display("FAIL fetch_ivalid_count got=%0d want=1", obsI.size()); end
    else begin
      got = obsI.pop_front();
      if (got !== want) begin failures++; $display("FAIL fetch_rdata got=%h want=%h", got, want); end
    end
    @(negedge clk);
    checks++; if (i_valid !== 1'b0) begin failures++; $display("FAIL fetch_pulse_width got=%b want=0", i_valid); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [31:0] got, want;
    mem[32'h200] = 32'h1234_5678; mem[32'h80] = 32'h0000_0013;
    dExp.push_back(32'h1234_5678); iExp.push_back(32'h0000_0013);
    d_addr = 32'h200; d_we = 1'b0; d_wstrb = 4'b1111; d_wdata = 32'h5555_AAAA;
    i_addr = 32'h80; d_req = 1'b1; i_req = 1'b1;
    runCycles(40, 2, 1);
    checks++; if (timedOut) begin failures++; $display("FAIL contention_done got=timeout want=2 valids"); end
    checks++; if ({ownerLog[0], ownerLog[1]} !== 2'b10) begin failures++; $display("FAIL contention_order got=%b%b want=10", ownerLog[0], ownerLog[1]); end
    checks++; if (grantStrb[0] !== 4'b0000) begin failures++; $display("FAIL load_strb got=%b want=0000", grantStrb[0]); end
    checks++; if (reqStartLog[1] !== 5) begin failures++; $display("FAIL contention_fetch_start got=%0d want=5", reqStartLog[1]); end
    checks++; if (bothValid) begin failures++; $display("FAIL contention_both_valid got=1 want=0"); end
    checks++;
    if (obsD.size() != 1 || obsI.size() != 1) begin
      failures++; $display("FAIL contention_valid_counts got=d%0d/i%0d want=d1/i1", obsD.size(), obsI.size());
    end else begin
      want = dExp.pop_front(); got = obsD.pop_front();
      if (got !== want) begin failures++; $display("FAIL contention_load_data got=%h want=%h", got, want); end
      want = iExp.pop_front(); got = obsI.pop_front();
      if (got !== want) begin failures++; $display("FAIL contention_fetch_data got=%h want=%h", got, want); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_store();
    logic [31:0] got, want;
    mem[32'h100] = 32'h0;
    dExp.push_back(32'h1234_5678);
    d_we = 1'b1; d_wstrb = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    runCycles(20, 1, 1);
    d_we = 1'b0;
    checks++; if (timedOut) begin failures++; $display("FAIL store_done got=timeout want=d_valid"); end
    checks++;
    if ({ownerLog[0], grantWe[0], grantStrb[0]} !== 6'b1_1_0011) begin
      failures++; $display("FAIL store_ctrl got=owner%b we%b strb%b want=owner1 we1 strb0011", ownerLog[0], grantWe[0], grantStrb[0]);
    end
    checks++;
    if (grantWdata[0] !== 32'hDEAD_BEEF || grantAddr[0] !== 32'h100) begin
      failures++; $display("FAIL store_addr_data got=%h@%h want=deadbeef@00000100", grantWdata[0], grantAddr[0]);
    end
    want = dExp.pop_front();
    checks++;
    if (obsD.size() != 1) begin failures++; $display("FAIL store_dvalid_count got=%0d want=1", obsD.size()); end
    else begin
      got = obsD.pop_front();
      if (got !== want) begin failures++; $display("FAIL store_drdata_kept got=%h want=%h", got, want); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_slow_memory();
    logic [31:0] got, want;
    mem[32'h44] = 32'h00A0_0113; gntDelay = 3; rvDelay = 4;
    iExp.push_back(32'h00A0_0113);
    i_addr = 32'h44; i_req = 1'b1;
    runCycles(40, 1, 1);
    gntDelay = 0; rvDelay = 0;
    checks++; if (reqCycles !== 4) begin failures++; $display("FAIL slow_req_cycles got=%0d want=4", reqCycles); end
    checks++; if (!addrStable) begin failures++; $display("FAIL slow_addr_stable got=changed want=stable"); end
    checks++; if (!busyAll) begin failures++; $display("FAIL slow_busy got=dropped want=held"); end
    checks++; if (firstValidCycle !== 10) begin failures++; $display("FAIL slow_latency got=%0d want=10", firstValidCycle); end
    want = iExp.pop_front();
    checks++;
    if (obsI.size() != 1) begin failures++; $display("FAIL slow_ivalid_count got=%0d want=1", obsI.size()); end
    else begin
      got = obsI.pop_front();
      if (got !== want) begin failures++; $display("FAIL slow_rdata got=%h want=%h", got, want); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_starvation();
    logic wantOwner [5];
    logic [31:0] got, want;
`ifdef ARB_STARVE_GUARD_EN
    wantOwner = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    wantOwner = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    mem[32'h300] = 32'hCAFE_0300; mem[32'h48] = 32'h0000_0048;
    for (int g = 0; g < 5; g++)
      if (wantOwner[g]) dExp.push_back(32'hCAFE_0300); else iExp.push_back(32'h0000_0048);
    d_we = 1'b0; d_addr = 32'h300; i_addr = 32'h48; d_req = 1'b1; i_req = 1'b1;
    runCycles(80, 5, 0);
    d_req = 1'b0; i_req = 1'b0;
    checks++; if (timedOut) begin failures++; $display("FAIL starve_done got=timeout want=5 valids"); end
    for (int g = 0; g < 5; g++) begin
      checks++;
      if (ownerLog[g] !== wantOwner[g]) begin
        failures++; $display("FAIL starve_grant%0d got=owner%b want=owner%b", g, ownerLog[g], wantOwner[g]);
      end
    end
    checks++;
    if (obsD.size() != dExp.size() || obsI.size() != iExp.size()) begin
      failures++; $display("FAIL starve_valid_counts got=d%0d/i%0d want=d%0d/i%0d", obsD.size(), obsI.size(), dExp.size(), iExp.size());
      dExp.delete(); iExp.delete();
    end else begin
      while (dExp.size() > 0) begin
        want = dExp.pop_front(); got = obsD.pop_front();
        if (got !== want) begin failures++; $display("FAIL starve_load_data got=%h want=%h", got, want); end
      end
      while (iExp.size() > 0) begin
        want = iExp.pop_front(); got = obsI.pop_front();
        if (got !== want) begin failures++; $display("FAIL starve_fetch_data got=%h want=%h", got, want); end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_resp();
    bit sawValid = 0, sawBusy = 0;
    gntDelay = 0; rvDelay = 6;
    i_addr = 32'h40; i_req = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_mid_req got=%b want=1", mem_req); end
    repeat (2) @(negedge clk);
    checks++; if ({busy, mem_req} !== 2'b10) begin failures++; $display("FAIL rst_mid_in_resp got=busy%b req%b want=busy1 req0", busy, mem_req); end
    i_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, i_rdata, d_rdata, i_valid, d_valid, owner, busy} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got busy=%b addr=%h i_rdata=%h d_rdata=%h want all zero", busy, mem_addr, i_rdata, d_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (i_valid || d_valid) sawValid = 1;
      if (busy) sawBusy = 1;
    end
    rvDelay = 0;
    checks++; if (sawValid) begin failures++; $display("FAIL rst_mid_stray_valid got=1 want=0"); end
    checks++; if (sawBusy || i_rdata !== 32'h0) begin failures++; $display("FAIL rst_mid_idle got=busy%b i_rdata=%h want=busy0 i_rdata=0", sawBusy, i_rdata); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_slow_memory();
    test_starvation();
    test_reset_mid_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
